regfile_commit_seq: RTL
=======================

# regfile_commit_seq

Sequential commit controller for the GPR/EFLAGS/EIP state of the x86 step circuit. It accepts one retire bundle per instruction with up to three GPR writes, an ALU flag update and the next EIP, and serializes the GPR writes one per cycle. It then applies flags and EIP and pulses `commit_done`. It holds the architectural register state that the single-write register update path cannot hold by itself. This covers multi-register instructions such as EDX:EAX results and string ops that adjust ECX/ESI/EDI.

## Interface
- `RESET_EIP`, 32'h0000_0000: EIP value after reset.
- `RESET_EFLAGS`, 32'h0000_0002: EFLAGS value after reset (bit 1 reserved-set).

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `init_load`  in  1  load initial state from `i_*`; honoured only in IDLE.
- `i_eax, i_ebx, i_ecx, i_edx, i_esi, i_edi, i_esp, i_ebp, i_eip, i_eflags`  in  32 each  initial state.
- `in_valid`  in  1  retire bundle valid.
- `in_ready`  out  1  bundle accepted when `in_valid && in_ready` at a rising edge.
- `in_wr_en`  in  3  per-slot GPR write enable; slot 0..2.
- `in_sel0, in_sel1, in_sel2`  in  3 each  GPR selector; standard x86 encoding (EAX=0, ECX=1, EDX=2, EBX=3, ESP=4, EBP=5, ESI=6, EDI=7).
- `in_data0, in_data1, in_data2`  in  32 each  write data per slot.
- `in_next_eip`  in  32  EIP after this instruction.
- `in_alu_wr`  in  1  apply `in_alu_flags`.
- `in_alu_flags`  in  6  bit 0 CF, 1 PF, 2 ZF, 3 SF, 4 OF, 5 DF.
- `o_eax … o_ebp, o_eip, o_eflags`  out  32 each  registered architectural state.
- `busy`  out  1  high in WRITE or FINAL.
- `commit_done`  out  1  one-cycle pulse per retired bundle.
- `retired`  out  32  count of retired bundles, wraps.

## Operation
- States: IDLE, WRITE, FINAL.
- `in_ready = (state==IDLE) && !init_load`.
- IDLE, `init_load=1`: all ten state registers load from `i_*` at the edge. `retired` is unchanged and no `commit_done` is produced. Takes priority over `in_valid`.
- IDLE, handshake: latch sel/data/eip/flags/alu_wr and set `pending = in_wr_en`. Go to WRITE if `pending!=0`, else FINAL.
- WRITE: each cycle, the lowest set bit of `pending` selects a slot. That slot's data is written to its selected GPR and its pending bit is cleared. Go to FINAL when the cleared bit was the last one.
- Duplicate selectors: writes occur in slot order, so the highest-numbered enabled slot wins.
- FINAL: `o_eip <= next_eip`.
  - If `alu_wr`, the flag bits are updated: CF→bit 0, PF→bit 2, ZF→bit 6, SF→bit 7, DF→bit 10, OF→bit 11. All other EFLAGS bits are preserved.
  - If not `alu_wr`, EFLAGS is unchanged.
  - `retired <= retired+1` (mod 2^32), `commit_done <= 1`, and the state goes to IDLE.
- `commit_done` is registered and is cleared at every edge where the state is not FINAL.
- Input bundle fields are ignored outside the handshake edge; changes during WRITE/FINAL have no effect.

## Timing
- Reset (async, immediate): state=IDLE, all GPRs=0, `o_eip=RESET_EIP`, `o_eflags=RESET_EFLAGS`, `retired=0`, `commit_done=0`, `busy=0`, pending cleared. Any bundle in flight is discarded with no partial completion signalled.
- Reset deassertion: `in_ready=1` in the first cycle after, provided `init_load=0`.
- Latency, with k = popcount(`in_wr_en`) and the handshake at edge N:
  - GPR writes become visible after edges N+1 … N+k.
  - EIP/EFLAGS update at edge N+k+1.
  - `commit_done` is high during cycle N+k+1…N+k+2, which is when `in_ready=1` again.
- Throughput: one bundle per k+2 cycles. A new handshake is allowed in the same cycle that `commit_done` is high.
- Outputs are register-only with no combinational path from inputs, except `in_ready`, which depends on `init_load`.

## Test plan
- Reset, then `init_load` with EAX=1…EDI=8, i_eip=0x1000, eflags=0x202 -> outputs equal the loads next cycle. `retired=0`, `commit_done` stays 0.
- Bundle `in_wr_en=3'b101`, sel0=EAX data 0xDEADBEEF, sel2=EDX data 0x1, next_eip=0x1005, alu_wr=0 -> EAX updates at N+1 and EDX at N+2. EIP=0x1005 at N+3. EFLAGS is unchanged, `commit_done` pulses once and `retired=1`.
- `in_wr_en=0`, alu_wr=1, flags=6'b111111 with eflags=0x2 -> FINAL at N+1 gives EFLAGS=0x0CC7.
- All three slots select ECX with data 1, 2, 3 -> final ECX=3 and 4 cycles of `busy`.
- Reset asserted mid-WRITE after slot 0 is written -> all outputs go to reset values immediately, with no `commit_done` and `retired=0`.
- Back-to-back bundles with `in_valid` held high, plus `init_load` asserted alongside `in_valid` in IDLE -> the second bundle is accepted in the `commit_done` cycle. `init_load` wins and the bundle waits.

Source files
------------

// File: rtl/regfile_commit_seq.sv
// Retire-bundle commit controller: serializes up to three GPR writes one per cycle,
// then applies EIP/EFLAGS and pulses commit_done.
module regfile_commit_seq #(
   parameter logic [31:0] RESET_EIP    = 32'h0000_0000,
   parameter logic [31:0] RESET_EFLAGS = 32'h0000_0002
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        init_load,
   input  logic [31:0] i_eax,
   input  logic [31:0] i_ebx,
   input  logic [31:0] i_ecx,
   input  logic [31:0] i_edx,
   input  logic [31:0] i_esi,
   input  logic [31:0] i_edi,
   input  logic [31:0] i_esp,
   input  logic [31:0] i_ebp,
   input  logic [31:0] i_eip,
   input  logic [31:0] i_eflags,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_wr_en,
   input  logic [2:0]  in_sel0,
   input  logic [2:0]  in_sel1,
   input  logic [2:0]  in_sel2,
   input  logic [31:0] in_data0,
   input  logic [31:0] in_data1,
   input  logic [31:0] in_data2,
   input  logic [31:0] in_next_eip,
   input  logic        in_alu_wr,
   input  logic [5:0]  in_alu_flags,
   output logic [31:0] o_eax,
   output logic [31:0] o_ebx,
   output logic [31:0] o_ecx,
   output logic [31:0] o_edx,
   output logic [31:0] o_esi,
   output logic [31:0] o_edi,
   output logic [31:0] o_esp,
   output logic [31:0] o_ebp,
   output logic [31:0] o_eip,
   output logic [31:0] o_eflags,
   output logic        busy,
   output logic        commit_done,
   output logic [31:0] retired
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_FINAL = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [2:0]  pending_q, pending_d;
   logic [2:0]  sel0_q, sel1_q, sel2_q;
   logic [31:0] data0_q, data1_q, data2_q;
   logic [31:0] next_eip_q;
   logic        alu_wr_q;
   logic [5:0]  alu_flags_q;
   logic [31:0] gpr_q [8];
   logic [31:0] eip_q;
   logic [31:0] eflags_q;
   logic [31:0] retired_q;
   logic        commit_done_q;

   logic [1:0]  slot;
   logic [2:0]  wr_sel;
   logic [31:0] wr_data;
   logic        accept;

   // Architectural flag positions: CF=0, PF=2, ZF=6, SF=7, DF=10, OF=11.
   function automatic logic [31:0] merge_flags(input logic [31:0] cur, input logic [5:0] alu);
      logic [31:0] res;
      res     = cur;
      res[0]  = alu[0];
      res[2]  = alu[1];
      res[6]  = alu[2];
      res[7]  = alu[3];
      res[11] = alu[4];
      res[10] = alu[5];
      return res;
   endfunction

   assign in_ready = (state_q == S_IDLE) && !init_load;
   assign accept   = in_ready && in_valid;

   always_comb begin
      slot = 2'd2;
      if (pending_q[0]) begin
         slot = 2'd0;
      end else if (pending_q[1]) begin
         slot = 2'd1;
      end
      case (slot)
         2'd0:    begin wr_sel = sel0_q; wr_data = data0_q; end
         2'd1:    begin wr_sel = sel1_q; wr_data = data1_q; end
         default: begin wr_sel = sel2_q; wr_data = data2_q; end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               pending_d = in_wr_en;
               state_d   = (in_wr_en != 3'b000) ? S_WRITE : S_FINAL;
            end
         end
         S_WRITE: begin
            pending_d = pending_q & ~(3'b001 << slot);
            if (pending_d == 3'b000) begin
               state_d = S_FINAL;
            end
         end
         default: begin
            pending_d = 3'b000;
            state_d   = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pending_q     <= 3'b000;
         sel0_q        <= 3'd0;
         sel1_q        <= 3'd0;
         sel2_q        <= 3'd0;
         data0_q       <= 32'd0;
         data1_q       <= 32'd0;
         data2_q       <= 32'd0;
         next_eip_q    <= 32'd0;
         alu_wr_q      <= 1'b0;
         alu_flags_q   <= 6'd0;
         for (int r = 0; r < 8; r++) begin
            gpr_q[r] <= 32'd0;
         end
         eip_q         <= RESET_EIP;
         eflags_q      <= RESET_EFLAGS;
         retired_q     <= 32'd0;
         commit_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         commit_done_q <= (state_q == S_FINAL);
         if (state_q == S_IDLE && init_load) begin
            gpr_q[0] <= i_eax;
            gpr_q[1] <= i_ecx;
            gpr_q[2] <= i_edx;
            gpr_q[3] <= i_ebx;
            gpr_q[4] <= i_esp;
            gpr_q[5] <= i_ebp;
            gpr_q[6] <= i_esi;
            gpr_q[7] <= i_edi;
            eip_q    <= i_eip;
            eflags_q <= i_eflags;
         end
         if (accept) begin
            sel0_q      <= in_sel0;
            sel1_q      <= in_sel1;
            sel2_q      <= in_sel2;
            data0_q     <= in_data0;
            data1_q     <= in_data1;
            data2_q     <= in_data2;
            next_eip_q  <= in_next_eip;
            alu_wr_q    <= in_alu_wr;
            alu_flags_q <= in_alu_flags;
         end
         if (state_q == S_WRITE) begin
            gpr_q[wr_sel] <= wr_data;
         end
         if (state_q == S_FINAL) begin
            eip_q     <= next_eip_q;
            retired_q <= retired_q + 32'd1;
            if (alu_wr_q) begin
               eflags_q <= merge_flags(eflags_q, alu_flags_q);
            end
         end
      end
   end

   assign o_eax       = gpr_q[0];
   assign o_ecx       = gpr_q[1];
   assign o_edx       = gpr_q[2];
   assign o_ebx       = gpr_q[3];
   assign o_esp       = gpr_q[4];
   assign o_ebp       = gpr_q[5];
   assign o_esi       = gpr_q[6];
   assign o_edi       = gpr_q[7];
   assign o_eip       = eip_q;
   assign o_eflags    = eflags_q;
   assign busy        = (state_q == S_WRITE) || (state_q == S_FINAL);
   assign commit_done = commit_done_q;
   assign retired     = retired_q;

endmodule
